// File: rtl/multi_btn_debouncer.sv
// N-channel button conditioner: 2-flop synchroniser, tick-gated stability counter,
// registered level and rise/fall pulses. Define DEBOUNCE_REPEAT_EN for hold auto-repeat.
module multi_btn_debouncer #(
   parameter int N_CH         = 4,
   parameter int STABLE_TICKS = 4,
   parameter int HOLD_TICKS   = 200,
   parameter int REPEAT_TICKS = 50
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            sample_tick,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] btn_rise,
   output logic [N_CH-1:0] btn_fall,
   output logic [N_CH-1:0] btn_repeat
);

   localparam int CNT_W = $clog2(STABLE_TICKS + 1);

   logic [N_CH-1:0]  sync_q1;
   logic [N_CH-1:0]  sync_q2;
   logic [CNT_W-1:0] stable_cnt [N_CH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q1   <= '0;
         sync_q2   <= '0;
         btn_level <= '0;
         btn_rise  <= '0;
         btn_fall  <= '0;
         for (int unsigned i = 0; i < N_CH; i++) stable_cnt[i] <= '0;
      end else begin
         sync_q1  <= btn_in;
         sync_q2  <= sync_q1;
         btn_rise <= '0;
         btn_fall <= '0;
         for (int unsigned i = 0; i < N_CH; i++) begin
            if (sample_tick) begin
               // any tick agreeing with the current level restarts qualification
               if (sync_q2[i] == btn_level[i]) begin
                  stable_cnt[i] <= '0;
               end else if (stable_cnt[i] == CNT_W'(STABLE_TICKS - 1)) begin
                  btn_level[i]  <= sync_q2[i];
                  btn_rise[i]   <= sync_q2[i];
                  btn_fall[i]   <= ~sync_q2[i];
                  stable_cnt[i] <= '0;
               end else begin
                  stable_cnt[i] <= stable_cnt[i] + 1'b1;
               end
            end
         end
      end
   end

`ifdef DEBOUNCE_REPEAT_EN
   localparam int HR_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
   localparam int HOLD_W = $clog2(HR_MAX + 1);

   logic [HOLD_W-1:0] hold_cnt [N_CH];
   logic [N_CH-1:0]   rep_phase;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         btn_repeat <= '0;
         rep_phase  <= '0;
         for (int unsigned i = 0; i < N_CH; i++) hold_cnt[i] <= '0;
      end else begin
         btn_repeat <= '0;
         for (int unsigned i = 0; i < N_CH; i++) begin
            if (!btn_level[i]) begin
               hold_cnt[i]  <= '0;
               rep_phase[i] <= 1'b0;
            end else if (sample_tick) begin
               // first interval is HOLD_TICKS, later ones REPEAT_TICKS; counter restarts at 0 each pulse
               if (hold_cnt[i] == (rep_phase[i] ? HOLD_W'(REPEAT_TICKS - 1)
                                                : HOLD_W'(HOLD_TICKS - 1))) begin
                  btn_repeat[i] <= 1'b1;
                  hold_cnt[i]   <= '0;
                  rep_phase[i]  <= 1'b1;
               end else begin
                  hold_cnt[i] <= hold_cnt[i] + 1'b1;
               end
            end
         end
      end
   end
`else
   assign btn_repeat = '0;
`endif

endmodule

// File: tb/tb_multi_btn_debouncer.sv
// Directed bench for multi_btn_debouncer; expected pulse events are queued with their
// due cycle and compared by a negedge monitor, which also demands silence otherwise.
module tb_multi_btn_debouncer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sample_tick;
   logic [3:0] btn_in;
   logic [3:0] btn_level, btn_rise, btn_fall, btn_repeat;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit mon_en   = 1'b0;

   typedef struct {
      int         cyc;
      logic [3:0] rise;
      logic [3:0] fall;
      logic [3:0] rep;
   } ev_t;
   ev_t sbq[$];

   multi_btn_debouncer #(
      .N_CH        (4),
      .STABLE_TICKS(4),
      .HOLD_TICKS  (10),
      .REPEAT_TICKS(3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_tick(sample_tick),
      .btn_in     (btn_in),
      .btn_level  (btn_level),
      .btn_rise   (btn_rise),
      .btn_fall   (btn_fall),
      .btn_repeat (btn_repeat)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push(input int c, input logic [3:0] r, input logic [3:0] f, input logic [3:0] p);
      ev_t e;
      e.cyc = c; e.rise = r; e.fall = f; e.rep = p;
      sbq.push_back(e);
   endtask

   task automatic run(input int n, input logic tk);
      repeat (n) begin
         sample_tick = tk;
         @(negedge clk);
      end
   endtask

   task automatic ticks4(input int n);
      repeat (n) begin
         run(1, 1'b1);
         run(3, 1'b0);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            ev_t e;
            e = sbq.pop_front();
            chk("ev_rise", btn_rise, e.rise);
            chk("ev_fall", btn_fall, e.fall);
            chk("ev_repeat", btn_repeat, e.rep);
         end else begin
            chk("idle_rise", btn_rise, 4'b0000);
            chk("idle_fall", btn_fall, 4'b0000);
            chk("idle_repeat", btn_repeat, 4'b0000);
         end
      end
   end

   initial begin
      int r;
      rst_n       = 1'b0;
      btn_in      = 4'b1111;
      sample_tick = 1'b1;

      // reset held 3 clk with all buttons pressed
      repeat (3) begin
         @(negedge clk);
         mon_en = 1'b1;
         chk("rst_level", btn_level, 4'b0000);
         chk("rst_rise", btn_rise, 4'b0000);
         chk("rst_fall", btn_fall, 4'b0000);
         chk("rst_repeat", btn_repeat, 4'b0000);
      end
      rst_n = 1'b1;
      push(cyc + 6, 4'b1111, 4'b0000, 4'b0000);
      run(10, 1'b1);
      chk("level_after_rst", btn_level, 4'b1111);

      btn_in = 4'b0000;
      push(cyc + 6, 4'b0000, 4'b1111, 4'b0000);
      run(10, 1'b1);
      chk("level_all_released", btn_level, 4'b0000);

      // ch0 bounces for 10 ticks, then settles high
      for (int i = 0; i < 10; i++) begin
         btn_in[0] = ~btn_in[0];
         ticks4(1);
      end
      chk("level_during_bounce", btn_level, 4'b0000);
      btn_in[0] = 1'b1;
      push(cyc + 17, 4'b0001, 4'b0000, 4'b0000);
      ticks4(6);
      chk("level_after_bounce", btn_level, 4'b0001);

      // ch2: press, 3-tick dropout (ignored), 4-tick dropout (released)
      btn_in[2] = 1'b1;
      push(cyc + 17, 4'b0100, 4'b0000, 4'b0000);
      ticks4(6);
      btn_in[2] = 1'b0;
      ticks4(3);
      btn_in[2] = 1'b1;
      ticks4(6);
      chk("level_short_dropout", btn_level, 4'b0101);
      btn_in[2] = 1'b0;
      push(cyc + 17, 4'b0000, 4'b0100, 4'b0000);
      ticks4(6);
      chk("level_ch2_released", btn_level, 4'b0001);

      // no ticks for 100 clk while inputs wander
      for (int i = 0; i < 100; i++) begin
         if (i < 90 && i % 5 == 0) btn_in = 4'($urandom_range(0, 15));
         else if (i == 90)         btn_in = 4'b1011;
         run(1, 1'b0);
      end
      chk("level_tick_gated", btn_level, 4'b0001);
      push(cyc + 4, 4'b1010, 4'b0000, 4'b0000);
      run(10, 1'b1);
      chk("level_ticks_resumed", btn_level, 4'b1011);

      // reset in the middle of ch1 release qualification
      btn_in = 4'b1001;
      run(4, 1'b1);
      rst_n = 1'b0;
      run(1, 1'b1);
      chk("midrst_level", btn_level, 4'b0000);
      run(1, 1'b1);
      chk("midrst_level2", btn_level, 4'b0000);
      rst_n = 1'b1;
      r = cyc + 6;
      push(r, 4'b1001, 4'b0000, 4'b0000);
`ifdef DEBOUNCE_REPEAT_EN
      push(r + 10, 4'b0000, 4'b0000, 4'b1001);
      push(r + 13, 4'b0000, 4'b0000, 4'b1001);
      push(r + 16, 4'b0000, 4'b0000, 4'b1001);
      push(r + 19, 4'b0000, 4'b0000, 4'b1001);
`endif
      run(r + 20 - cyc, 1'b1);
      chk("level_held", btn_level, 4'b1001);
      btn_in = 4'b0000;
`ifdef DEBOUNCE_REPEAT_EN
      push(r + 22, 4'b0000, 4'b0000, 4'b1001);
      push(r + 25, 4'b0000, 4'b0000, 4'b1001);
`endif
      push(r + 26, 4'b0000, 4'b1001, 4'b0000);
      run(40, 1'b1);
      chk("level_final", btn_level, 4'b0000);

      checks++;
      assert (sbq.size() == 0) else begin
         failures++;
         $error("FAIL pending_events observed=%0d expected=0", sbq.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
